// File: rtl/pie_decoder.sv
// PIE downlink receiver: measures rising-edge intervals, validates delimiter/data-0/RTCAL/TRCAL
// and slices data symbols against RTCAL/2. Define PIE_GLITCH_FILTER_EN to enable the input deglitcher.
module pie_decoder #(
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned DELIM_MIN    = 2,
    parameter int unsigned DELIM_MAX    = 6,
    parameter int unsigned IDLE_TIMEOUT = 128,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned GLITCH_LEN   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_pie,
    output logic                 out_dat,
    output logic                 out_vld,
    output logic [CNT_WIDTH-1:0] rtcal,
    output logic [CNT_WIDTH-1:0] trcal,
    output logic                 trcal_vld,
    output logic                 frame_active,
    output logic                 frame_done,
    output logic                 err
);

    localparam int unsigned XW = CNT_WIDTH + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELIM = 3'd1;
    localparam logic [2:0] S_DATA0 = 3'd2;
    localparam logic [2:0] S_RTCAL = 3'd3;
    localparam logic [2:0] S_CAL3  = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;

    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("SYNC_STAGES must be at least 2");
    end
    if (GLITCH_LEN < 1) begin : g_glitch_chk
        $error("GLITCH_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_line;
    logic                   r_line_d;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_lcnt;
    logic [CNT_WIDTH-1:0]   r_d0;
    logic [2:0]             r_state;

    // Preset to idle-high so reset release never creates a false edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], in_pie};
    end
    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIE_GLITCH_FILTER_EN
    localparam int unsigned GW = $clog2(GLITCH_LEN + 1);
    logic          r_filt;
    logic [GW-1:0] r_gcnt;

    // New level accepted only after GLITCH_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 1'b1;
            r_gcnt <= '0;
        end else if (w_sync == r_filt) begin
            r_gcnt <= '0;
        end else if (r_gcnt == GW'(GLITCH_LEN - 1)) begin
            r_filt <= w_sync;
            r_gcnt <= '0;
        end else begin
            r_gcnt <= r_gcnt + GW'(1);
        end
    end
    assign w_line = r_filt;
`else
    assign w_line = w_sync;
`endif

    logic                 w_rise;
    logic                 w_fall;
    logic [CNT_WIDTH-1:0] w_len;
    logic [CNT_WIDTH-1:0] w_llen;
    logic [CNT_WIDTH-1:0] w_pivot;
    logic [XW-1:0]        w_len_x;
    logic [XW-1:0]        w_d0x2;
    logic [XW-1:0]        w_d0x4;
    logic                 w_delim_ok;
    logic                 w_rt_ok;
    logic                 w_timeout;

    assign w_rise     = w_line & ~r_line_d;
    assign w_fall     = ~w_line & r_line_d;
    // Interval lengths at the edge cycle; counters saturate at all-ones
    assign w_len      = (r_cnt == '1)  ? r_cnt  : r_cnt + CNT_WIDTH'(1);
    assign w_llen     = (r_lcnt == '1) ? r_lcnt : r_lcnt + CNT_WIDTH'(1);
    assign w_pivot    = rtcal >> 1;
    assign w_len_x    = XW'(w_len);
    assign w_d0x2     = {1'b0, r_d0, 1'b0};
    assign w_d0x4     = {r_d0, 2'b00};
    assign w_delim_ok = (w_llen >= CNT_WIDTH'(DELIM_MIN)) && (w_llen <= CNT_WIDTH'(DELIM_MAX));
    assign w_rt_ok    = (w_len_x > w_d0x2) && (w_len_x < w_d0x4);
    assign w_timeout  = r_cnt > CNT_WIDTH'(IDLE_TIMEOUT);

    logic [2:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_d0_nxt;
    logic [CNT_WIDTH-1:0] w_rtcal_nxt;
    logic [CNT_WIDTH-1:0] w_trcal_nxt;
    logic                 w_tvld_nxt;
    logic                 w_fa_nxt;
    logic                 w_dat_nxt;
    logic                 w_vld_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_d0_nxt    = r_d0;
        w_rtcal_nxt = rtcal;
        w_trcal_nxt = trcal;
        w_tvld_nxt  = trcal_vld;
        w_fa_nxt    = frame_active;
        w_dat_nxt   = out_dat;
        w_vld_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_DELIM;
            end
            S_DELIM: begin
                if (w_rise) begin
                    if (w_delim_ok) begin
                        w_state_nxt = S_DATA0;
                        w_fa_nxt    = 1'b1;
                        w_rtcal_nxt = '0;
                        w_trcal_nxt = '0;
                        w_tvld_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA0, S_RTCAL, S_CAL3: begin
                if (w_rise) begin
                    w_state_nxt = S_DATA;
                    if (r_state == S_DATA0) begin
                        w_d0_nxt    = w_len;
                        w_state_nxt = S_RTCAL;
                    end else if (r_state == S_RTCAL) begin
                        if (w_rt_ok) begin
                            w_rtcal_nxt = w_len;
                            w_state_nxt = S_CAL3;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_fa_nxt    = 1'b0;
                            w_state_nxt = S_IDLE;
                        end
                    end else if (w_len > rtcal) begin
                        w_trcal_nxt = w_len;
                        w_tvld_nxt  = 1'b1;
                    end else begin
                        // Frame-sync: this interval is already the first data symbol
                        w_dat_nxt = w_len > w_pivot;
                        w_vld_nxt = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_fa_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_rise) begin
                    w_dat_nxt = w_len > w_pivot;
                    w_vld_nxt = 1'b1;
                end else if (r_cnt >= rtcal) begin
                    w_done_nxt  = 1'b1;
                    w_fa_nxt    = 1'b0;
                    // Low line here means the next delimiter has already begun
                    w_state_nxt = w_line ? S_IDLE : S_DELIM;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_line_d     <= 1'b1;
            r_cnt        <= '0;
            r_lcnt       <= '0;
            r_d0         <= '0;
            rtcal        <= '0;
            trcal        <= '0;
            trcal_vld    <= 1'b0;
            frame_active <= 1'b0;
            out_dat      <= 1'b0;
            out_vld      <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_line_d     <= w_line;
            r_cnt        <= w_rise ? '0 : w_len;
            r_lcnt       <= w_fall ? '0 : w_llen;
            r_d0         <= w_d0_nxt;
            rtcal        <= w_rtcal_nxt;
            trcal        <= w_trcal_nxt;
            trcal_vld    <= w_tvld_nxt;
            frame_active <= w_fa_nxt;
            out_dat      <= w_dat_nxt;
            out_vld      <= w_vld_nxt;
            frame_done   <= w_done_nxt;
            err          <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_pie_decoder.sv
// Directed bench for pie_decoder: query/frame-sync decode, bad delimiter, bad RTCAL,
// mid-frame reset, and (with PIE_GLITCH_FILTER_EN) a glitched data-1 symbol.
module tb_pie_decoder;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_pie;
    logic          out_dat;
    logic          out_vld;
    logic [CW-1:0] rtcal;
    logic [CW-1:0] trcal;
    logic          trcal_vld;
    logic          frame_active;
    logic          frame_done;
    logic          err;

    pie_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .in_pie       (in_pie),
        .out_dat      (out_dat),
        .out_vld      (out_vld),
        .rtcal        (rtcal),
        .trcal        (trcal),
        .trcal_vld    (trcal_vld),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    int          n_bits = 0;
    int          n_done = 0;
    int          n_errp = 0;
    int          n_ovl  = 0;
    logic [31:0] bits_rx = '0;
    bit          fa_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld) begin
                if (n_bits < 32) bits_rx[n_bits] = out_dat;
                n_bits++;
            end
            if (frame_done) n_done++;
            if (err) n_errp++;
            if (frame_done && (err || out_vld)) n_ovl++;
            if (frame_active) fa_seen = 1'b1;
        end
    end

    task automatic clr_mon();
        n_bits  = 0;
        n_done  = 0;
        n_errp  = 0;
        bits_rx = '0;
        fa_seen = 1'b0;
    endtask

    task automatic drive(input bit v, input int n);
        in_pie = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sym(input int len, input int pw);
        drive(1'b1, len - pw);
        drive(1'b0, pw);
    endtask

    task automatic frame(input int delim, input int d0, input int rt, input int tr,
                         input logic [7:0] bits, input int nb, input int pw);
        drive(1'b0, delim);
        sym(d0, pw);
        sym(rt, pw);
        if (tr != 0) sym(tr, pw);
        for (int i = 0; i < nb; i++) sym(bits[i] ? 10 : 6, pw);
        drive(1'b1, 40);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        in_pie = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 32'({out_dat, out_vld, trcal_vld, frame_active, frame_done, err}), 0);
        check("rst_rtcal", 32'(rtcal), 0);
        check("rst_trcal", 32'(trcal), 0);
        rst = 1'b0;
        drive(1'b1, 10);

        // Query preamble, bits 1,0,1
        clr_mon();
        frame(3, 6, 16, 32, 8'b0000_0101, 3, 2);
        check("q_nbits", 32'(n_bits), 3);
        check("q_bits", bits_rx, 32'h5);
        check("q_done", 32'(n_done), 1);
        check("q_err", 32'(n_errp), 0);
        check("q_rtcal", 32'(rtcal), 16);
        check("q_trcal", 32'(trcal), 32);
        check("q_tvld", 32'(trcal_vld), 1);
        check("q_fa_seen", 32'(fa_seen), 1);
        check("q_fa_end", 32'(frame_active), 0);

        // Frame-sync, bits 0,1
        clr_mon();
        frame(3, 6, 16, 0, 8'b0000_0010, 2, 2);
        check("fs_nbits", 32'(n_bits), 2);
        check("fs_bits", bits_rx, 32'h2);
        check("fs_done", 32'(n_done), 1);
        check("fs_tvld", 32'(trcal_vld), 0);
        check("fs_trcal", 32'(trcal), 0);
        check("fs_rtcal", 32'(rtcal), 16);

        // Over-long delimiter; 1-cycle symbol lows are too short to act as delimiters
        clr_mon();
        frame(10, 6, 16, 0, 8'b0000_0010, 2, 1);
        check("ld_nbits", 32'(n_bits), 0);
        check("ld_err", 32'(n_errp), 0);
        check("ld_fa_seen", 32'(fa_seen), 0);
        check("ld_done", 32'(n_done), 0);

        // RTCAL 10 with data-0 6 is below 2*d0
        clr_mon();
        drive(1'b0, 3);
        sym(6, 2);
        sym(10, 2);
        drive(1'b1, 40);
        check("rt_err", 32'(n_errp), 1);
        check("rt_nbits", 32'(n_bits), 0);
        check("rt_done", 32'(n_done), 0);
        check("rt_fa_seen", 32'(fa_seen), 1);
        check("rt_fa_end", 32'(frame_active), 0);

        // Reset right after the second data bit
        clr_mon();
        drive(1'b0, 3);
        sym(6, 2);
        sym(16, 2);
        sym(32, 2);
        sym(10, 2);
        sym(6, 2);
        drive(1'b1, 4);
        check("mr_nbits", 32'(n_bits), 2);
        check("mr_fa_before", 32'(frame_active), 1);
        rst = 1'b1;
        #1;
        check("mr_flags", 32'({out_dat, out_vld, trcal_vld, frame_active, frame_done, err}), 0);
        check("mr_rtcal", 32'(rtcal), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 40);
        check("mr_done", 32'(n_done), 0);
        check("mr_err", 32'(n_errp), 0);

        // Full frame after reset, bits 0,1,1
        clr_mon();
        frame(3, 6, 16, 32, 8'b0000_0110, 3, 2);
        check("ar_nbits", 32'(n_bits), 3);
        check("ar_bits", bits_rx, 32'h6);
        check("ar_done", 32'(n_done), 1);
        check("ar_rtcal", 32'(rtcal), 16);
        check("ar_trcal", 32'(trcal), 32);

`ifdef PIE_GLITCH_FILTER_EN
        // 1-cycle low glitch inside the high part of a data-1 symbol
        clr_mon();
        drive(1'b0, 3);
        sym(6, 2);
        sym(16, 2);
        sym(6, 2);
        drive(1'b1, 3);
        drive(1'b0, 1);
        drive(1'b1, 4);
        drive(1'b0, 2);
        sym(10, 2);
        drive(1'b1, 40);
        check("gl_nbits", 32'(n_bits), 3);
        check("gl_bits", bits_rx, 32'h6);
        check("gl_done", 32'(n_done), 1);
        check("gl_err", 32'(n_errp), 0);
`endif

        check("no_overlap", 32'(n_ovl), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pie_decoder.md
Name: pie_decoder

Overview:
- Tag-side receiver for the reader's PIE downlink: recovers command bits from the pulse-interval-encoded waveform driven by the reader TX path.
- Decodes delimiter, data-0, RTCAL and optional TRCAL (frame-sync vs preamble), then slices each data symbol against pivot = RTCAL/2.
- Sits in the tag-emulator / loopback bench path and feeds a downstream command parser and CRC5/CRC16 checkers through an out_dat/out_vld bit stream.

Parameters:
CNT_WIDTH, 8, width of interval counter and of rtcal/trcal outputs
DELIM_MIN, 2, minimum accepted delimiter low length (cycles)
DELIM_MAX, 6, maximum accepted delimiter low length (cycles)
IDLE_TIMEOUT, 128, max cycles without a rising edge before DATA state is reached; exceeding it raises err
SYNC_STAGES, 2, input synchroniser flops
GLITCH_LEN, 2, stability requirement used only with PIE_GLITCH_FILTER_EN

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
in_pie  input  1  raw PIE line, idle high, asynchronous to clk
out_dat  output  1  decoded bit, valid when out_vld
out_vld  output  1  one-cycle strobe per decoded bit
rtcal  output  CNT_WIDTH  measured RTCAL, held until next frame
trcal  output  CNT_WIDTH  measured TRCAL, held until next frame
trcal_vld  output  1  high from TRCAL capture until next frame start (preamble seen)
frame_active  output  1  high from delimiter acceptance to frame end
frame_done  output  1  one-cycle pulse at normal frame end
err  output  1  one-cycle pulse on aborted frame

Behaviour:
- Reset (async): all outputs 0, FSM IDLE, counters 0, sync chain preset to 1 (idle).
- "Interval" = clk count between consecutive synchronised rising edges; count saturates at all-ones.
- Output strobes asserted one cycle after the cycle in which the synchronised rising edge is detected.
- IDLE: on falling edge -> DELIM, clear counter.
- DELIM: count low; on rising edge, if DELIM_MIN <= len <= DELIM_MAX -> DATA0, frame_active=1, clear rtcal/trcal/trcal_vld; else -> IDLE silently.
- DATA0: interval latched as d0 -> RTCAL.
- RTCAL: interval latched; if 2*d0 < len < 4*d0 -> rtcal=len, go CAL3; else err, -> IDLE.
- CAL3: interval len > rtcal -> trcal=len, trcal_vld=1, -> DATA; else treat as first data bit (out_dat = len > rtcal>>1), out_vld, -> DATA.
- DATA: each interval emits out_dat = (len > rtcal>>1), out_vld. len == pivot decodes 0.
- Frame end: in DATA, counter reaches rtcal+1 without rising edge -> frame_done pulse, frame_active=0, -> IDLE (or DELIM if line currently low and falling edge pending is treated as new delimiter start).
- States DATA0/RTCAL/CAL3: counter exceeds IDLE_TIMEOUT -> err, frame_active=0, -> IDLE.
- frame_done and err never assert in same cycle; out_vld never coincides with frame_done.
- Pivot computed as rtcal>>1 (truncating); comparisons unsigned, CNT_WIDTH bits.
- Reset mid-frame: immediate return to IDLE, no frame_done/err emitted.

Optional Feature:
PIE_GLITCH_FILTER_EN: when defined, a synchronised level change is accepted only after GLITCH_LEN consecutive equal samples; all intervals shift uniformly by the filter delay, so measured lengths are unchanged, and pulses shorter than GLITCH_LEN are ignored. When undefined, edges are taken directly from the last sync stage.

Test Plan:
- Query preamble, encoder timing (PW=2, data0=6, data1=10, RTCAL=16, TRCAL=32, delim=3), bits 1,0,1 -> rtcal=16, trcal=32, trcal_vld=1, out_dat 1,0,1 on three strobes, frame_done once.
- Frame-sync (no TRCAL) then bits 0,1 -> trcal_vld=0, first strobe 0 emitted from CAL3, then 1, frame_done once.
- Delimiter low for 10 cycles followed by valid frame body -> no strobes, no err, frame_active stays 0.
- RTCAL of 10 with data0=6 (< 2*d0) -> single err pulse, frame_active drops, no out_vld.
- Assert rst for one cycle after second data bit -> outputs immediately 0, no frame_done; a subsequent full frame decodes correctly.
- With PIE_GLITCH_FILTER_EN, a 1-cycle low glitch inside a data-1 high period -> still decodes 1, bit count unchanged.
